rf_write_arbiter: RTL and testbench

Arbiter and sequencer for the register file's single write port (WE3/A3/WD3). It shares that port between the pipeline writeback stage and the SPI load path, which lets an SPI master preload registers while the core runs. The pipeline always has priority. SPI writes are buffered in a small FIFO and drained into idle write-port cycles. A starvation counter raises a pipeline stall request so that buffered SPI writes are guaranteed to retire.

---
 rtl/rf_write_arbiter.sv | 123 ++++++++++++
 tb/tb_rf_write_arbiter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/rf_write_arbiter.sv
// rtl/rf_write_arbiter.sv - register file write-port arbiter: pipeline priority, buffered SPI loads, starvation stall
module rf_write_arbiter #(
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wb_we,
    input  logic [4:0]               wb_addr,
    input  logic [31:0]              wb_data,
    input  logic                     spi_valid,
    input  logic [4:0]               spi_addr,
    input  logic [31:0]              spi_data,
    output logic                     spi_ready,
    output logic                     WE3,
    output logic [4:0]               A3,
    output logic [31:0]              WD3,
    output logic                     spi_commit,
    output logic                     stall_req,
    output logic [$clog2(DEPTH):0]   pending
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [4:0]    addr_mem [DEPTH];
    logic [31:0]   data_mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic [CW-1:0] count_nxt;
    logic [7:0]    starve_cnt;
    logic [7:0]    starve_nxt;

    logic          wb_act;
    logic          non_empty;
    logic          push;
    logic          pop;
    logic [4:0]    head_addr;
    logic [31:0]   head_data;

    // Arbitration decisions: pipeline wins, FIFO drains only into idle cycles and never while in reset
    always_comb begin
        wb_act    = wb_we && (wb_addr != 5'd0);
        non_empty = (count != '0);
        spi_ready = (count < CW'(DEPTH));
        push      = !rst && spi_valid && spi_ready;
        pop       = !rst && !wb_act && non_empty;
        head_addr = addr_mem[rd_ptr];
        head_data = data_mem[rd_ptr];
        pending   = count;
    end

    // Next occupancy and starvation count, shared by the state register and the stall logic
    always_comb begin
        count_nxt = count;
        if (push && !pop) begin
            count_nxt = count + CW'(1);
        end else if (pop && !push) begin
            count_nxt = count - CW'(1);
        end

        starve_nxt = starve_cnt;
        if (pop || !non_empty) begin
            starve_nxt = 8'd0;
        end else if (wb_act && (starve_cnt < 8'(STARVE_MAX))) begin
            starve_nxt = starve_cnt + 8'd1;
        end
    end

    // Write-port mux: zero-latency pipeline pass-through, else FIFO head (x0 entries retire without a write)
    always_comb begin
        WE3        = 1'b0;
        A3         = 5'd0;
        WD3        = 32'd0;
        spi_commit = 1'b0;
        if (wb_act) begin
            WE3 = 1'b1;
            A3  = wb_addr;
            WD3 = wb_data;
        end else if (pop) begin
            WE3        = (head_addr != 5'd0);
            A3         = head_addr;
            WD3        = head_data;
            spi_commit = 1'b1;
        end
    end

    // FIFO storage; contents need no reset because occupancy gates every read
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[wr_ptr] <= spi_addr;
            data_mem[wr_ptr] <= spi_data;
        end
    end

    // Pointers, occupancy, starvation counter and the sticky stall request
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            starve_cnt <= 8'd0;
            stall_req  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count      <= count_nxt;
            starve_cnt <= starve_nxt;
            // Once raised, stall stays up until the whole backlog has retired
            if (count_nxt == '0) begin
                stall_req <= 1'b0;
            end else if (starve_nxt == 8'(STARVE_MAX)) begin
                stall_req <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// tb/tb_rf_write_arbiter.sv - directed self-checking bench for rf_write_arbiter
module tb_rf_write_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        spi_valid;
    logic [4:0]  spi_addr;
    logic [31:0] spi_data;
    logic        spi_ready;
    logic        WE3;
    logic [4:0]  A3;
    logic [31:0] WD3;
    logic        spi_commit;
    logic        stall_req;
    logic [2:0]  pending;

    int checks   = 0;
    int failures = 0;

    rf_write_arbiter #(.DEPTH(4), .STARVE_MAX(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .wb_we      (wb_we),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .spi_valid  (spi_valid),
        .spi_addr   (spi_addr),
        .spi_data   (spi_data),
        .spi_ready  (spi_ready),
        .WE3        (WE3),
        .A3         (A3),
        .WD3        (WD3),
        .spi_commit (spi_commit),
        .stall_req  (stall_req),
        .pending    (pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; wb_we = 1'b0; wb_addr = 5'd0; wb_data = 32'd0;
        spi_valid = 1'b1; spi_addr = 5'd9; spi_data = 32'd1;

        // reset held two edges with spi_valid high
        tick(); tick();
        #1;
        chk("rst_pending", pending, 0);
        chk("rst_ready", spi_ready, 1);
        chk("rst_stall", stall_req, 0);
        chk("rst_commit", spi_commit, 0);
        chk("rst_we", WE3, 0);

        // first push after release
        rst = 1'b0;
        tick();
        spi_valid = 1'b0;
        #1;
        chk("first_pending", pending, 1);
        chk("first_commit", spi_commit, 1);
        chk("first_a3", A3, 9);
        chk("first_wd3", WD3, 1);
        tick();
        chk("first_empty", pending, 0);
        chk("first_idle_we", WE3, 0);

        // idle drain, no write-through in the push cycle
        spi_valid = 1'b1; spi_addr = 5'd5; spi_data = 32'hDEADBEEF;
        #1;
        chk("idle_nowt_we", WE3, 0);
        chk("idle_nowt_commit", spi_commit, 0);
        tick();
        spi_valid = 1'b0;
        #1;
        chk("idle_we", WE3, 1);
        chk("idle_a3", A3, 5);
        chk("idle_wd3", WD3, 32'hDEADBEEF);
        chk("idle_commit", spi_commit, 1);
        tick();
        chk("idle_pending", pending, 0);

        // pipeline priority over a buffered entry
        spi_valid = 1'b1; spi_addr = 5'd3; spi_data = 32'h11;
        wb_we = 1'b1; wb_addr = 5'd7; wb_data = 32'h22;
        #1;
        chk("prio_push_a3", A3, 7);
        tick();
        spi_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("prio_a3", A3, 7);
            chk("prio_wd3", WD3, 32'h22);
            chk("prio_commit", spi_commit, 0);
            chk("prio_pending", pending, 1);
            tick();
        end
        wb_we = 1'b0;
        #1;
        chk("prio_drain_we", WE3, 1);
        chk("prio_drain_a3", A3, 3);
        chk("prio_drain_wd3", WD3, 32'h11);
        chk("prio_drain_commit", spi_commit, 1);
        tick();
        chk("prio_empty", pending, 0);

        // full / backpressure
        wb_we = 1'b1; wb_addr = 5'd7; wb_data = 32'h22;
        for (int i = 0; i < 4; i++) begin
            spi_valid = 1'b1; spi_addr = 5'(10 + i); spi_data = 32'(100 + i);
            #1;
            chk("full_ready_pre", spi_ready, 1);
            tick();
        end
        chk("full_pending4", pending, 4);
        chk("full_ready0", spi_ready, 0);
        spi_addr = 5'd14; spi_data = 32'd104;
        tick();
        chk("full_held", pending, 4);
        wb_we = 1'b0;
        #1;
        chk("full_pop_commit", spi_commit, 1);
        chk("full_pop_a3", A3, 10);
        tick();
        chk("full_after_pop", pending, 3);
        chk("full_ready1", spi_ready, 1);
        wb_we = 1'b1;
        tick();
        spi_valid = 1'b0;
        chk("full_fifth_in", pending, 4);
        wb_we = 1'b0;
        for (int i = 1; i < 5; i++) begin
            #1;
            chk("full_order_a3", A3, 10 + i);
            chk("full_order_wd3", WD3, 100 + i);
            chk("full_order_commit", spi_commit, 1);
            tick();
        end
        chk("full_empty", pending, 0);

        // starvation: entries arrive while pipeline stays busy
        wb_we = 1'b1; wb_addr = 5'd7; wb_data = 32'h22;
        spi_valid = 1'b1; spi_addr = 5'd20; spi_data = 32'd200;
        tick();
        for (int k = 1; k <= 9; k++) begin
            spi_valid = (k <= 2);
            spi_addr  = 5'(20 + k);
            spi_data  = 32'(200 + k);
            #1;
            chk("starve_stall", stall_req, (k == 9));
            tick();
        end
        chk("starve_pending", pending, 3);
        chk("starve_hold", stall_req, 1);
        wb_we = 1'b0;
        for (int j = 0; j < 3; j++) begin
            #1;
            chk("starve_drain_a3", A3, 20 + j);
            chk("starve_drain_commit", spi_commit, 1);
            chk("starve_drain_stall", stall_req, 1);
            tick();
        end
        chk("starve_release", stall_req, 0);
        chk("starve_empty", pending, 0);

        // x0 SPI entry retires without a write
        spi_valid = 1'b1; spi_addr = 5'd0; spi_data = 32'h55;
        tick();
        spi_valid = 1'b0;
        #1;
        chk("x0_pending", pending, 1);
        chk("x0_commit", spi_commit, 1);
        chk("x0_we", WE3, 0);
        tick();
        chk("x0_empty", pending, 0);

        // pipeline write to x0 counts as idle
        wb_we = 1'b1; wb_addr = 5'd0; wb_data = 32'h77;
        spi_valid = 1'b1; spi_addr = 5'd6; spi_data = 32'h66;
        #1;
        chk("wbx0_we", WE3, 0);
        tick();
        spi_valid = 1'b0;
        #1;
        chk("wbx0_drain_we", WE3, 1);
        chk("wbx0_drain_a3", A3, 6);
        chk("wbx0_drain_wd3", WD3, 32'h66);
        chk("wbx0_commit", spi_commit, 1);
        tick();
        chk("wbx0_empty", pending, 0);

        // reset mid-operation discards backlog, pipeline still passes through
        wb_we = 1'b1; wb_addr = 5'd7; wb_data = 32'h33;
        spi_valid = 1'b1; spi_addr = 5'd8; spi_data = 32'h88;
        tick(); tick();
        spi_valid = 1'b0;
        chk("mid_pending", pending, 2);
        rst = 1'b1;
        #1;
        chk("mid_rst_we", WE3, 1);
        chk("mid_rst_a3", A3, 7);
        chk("mid_rst_wd3", WD3, 32'h33);
        wb_we = 1'b0;
        #1;
        chk("mid_rst_nocommit", spi_commit, 0);
        tick();
        rst = 1'b0;
        #1;
        chk("mid_after_pending", pending, 0);
        chk("mid_after_commit", spi_commit, 0);
        chk("mid_after_we", WE3, 0);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
